// File: rtl/c_align_pkg.sv
// Shared types and helpers for the RV32IC fetch realigner.
package c_align_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        SKIP = 1'b1
    } align_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic is_rvc(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/c_hw_fifo.sv
// Circular halfword store: pushes and pops up to two halfwords per cycle, exposes the two head entries.
module c_hw_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear_n,
    input  logic [1:0]                 push_n,
    input  logic [15:0]                push_hw0,
    input  logic [15:0]                push_hw1,
    input  logic [1:0]                 pop_n,
    output logic [15:0]                h0,
    output logic [15:0]                h1,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] head_next;
    logic [PW-1:0] head_plus1;
    logic [PW-1:0] tail0;
    logic [PW-1:0] tail1;
    logic [CW-1:0] count_next;

    // Modulo works for any depth, not just powers of two.
    function automatic logic [PW-1:0] wrap(input int base, input int off);
        return PW'((base + off) % DEPTH);
    endfunction

    always_comb begin
        head_plus1 = wrap(int'(head), 1);
        head_next  = wrap(int'(head), int'(pop_n));
        tail0      = wrap(int'(head), int'(count));
        tail1      = wrap(int'(head), int'(count) + 1);
        count_next = count + CW'(push_n) - CW'(pop_n);
    end

    assign h0 = mem[head];
    assign h1 = mem[head_plus1];

    // Writes land past the live entries; the caller never pushes beyond DEPTH.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) begin
            mem[tail0] <= push_hw0;
        end
        if (push_n == 2'd2) begin
            mem[tail1] <= push_hw1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !clear_n) begin
            head  <= '0;
            count <= '0;
        end else begin
            head  <= head_next;
            count <= count_next;
        end
    end

endmodule

// File: rtl/c_fetch_realigner.sv
// Halfword realigner between the 32-bit fetch port and an RV32IC decoder, with per-instruction PC.
module c_fetch_realigner
    import c_align_pkg::*;
#(
    parameter int              BUF_HW   = 4,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_valid,
    input  logic [31:0]     fetch_data,
    output logic            fetch_ready,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_out,
    output logic [PC_W-1:0] inst_pc,
    output logic            inst_is_c
);

    localparam int CW = $clog2(BUF_HW+1);

    align_state_t  state_q;
    align_state_t  state_d;
    logic [CW-1:0] count;
    logic [15:0]   h0;
    logic [15:0]   h1;
    logic          head_rvc;
    logic          push;
    logic          pop;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    logic [15:0]   push_hw0;

    assign head_rvc = is_rvc(h0);
    assign push     = fetch_valid && fetch_ready;
    assign pop      = inst_valid && inst_ready;

    c_hw_fifo #(
        .DEPTH(BUF_HW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_n (!flush),
        .push_n  (push_n),
        .push_hw0(push_hw0),
        .push_hw1(fetch_data[31:16]),
        .pop_n   (pop_n),
        .h0      (h0),
        .h1      (h1),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // A flush to an odd halfword arms SKIP so the first word's lower half is discarded.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = flush_pc[1] ? SKIP : RUN;
        end else if (state_q == SKIP && push) begin
            state_d = RUN;
        end
    end

    always_comb begin
        fetch_ready = 1'b0;
        push_n      = 2'd0;
        push_hw0    = fetch_data[15:0];
        if (state_q == SKIP) begin
            fetch_ready = !flush && (count <= CW'(BUF_HW-1));
            push_hw0    = fetch_data[31:16];
            if (push) begin
                push_n = 2'd1;
            end
        end else begin
            fetch_ready = !flush && (count <= CW'(BUF_HW-2));
            if (push) begin
                push_n = 2'd2;
            end
        end
    end

    // Length decode looks at the head halfword only; a 32-bit head needs both halves buffered.
    always_comb begin
        inst_valid = !flush && (count != '0) && (head_rvc || count >= CW'(2));
        inst_is_c  = inst_valid && head_rvc;
        inst_out   = NOP_INST;
        pop_n      = 2'd0;
        if (inst_valid) begin
            inst_out = head_rvc ? {16'h0000, h0} : {h1, h0};
        end
        if (pop) begin
            pop_n = head_rvc ? 2'd1 : 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inst_pc <= RESET_PC;
        end else if (flush) begin
            inst_pc <= {flush_pc[PC_W-1:1], 1'b0};
        end else if (pop) begin
            inst_pc <= inst_pc + (head_rvc ? PC_W'(2) : PC_W'(4));
        end
    end

endmodule

// File: tb/tb_c_fetch_realigner.sv
// Directed self-checking bench for c_fetch_realigner with hand-computed expectations.
module tb_c_fetch_realigner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_data = '0;
    logic        fetch_ready;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_is_c;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0010_0093;
    localparam logic [31:0] W1  = 32'h0020_0113;
    localparam logic [31:0] W2  = 32'h0030_0193;
    localparam logic [31:0] W3  = 32'h0040_0213;

    c_fetch_realigner #(
        .BUF_HW  (4),
        .PC_W    (32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .fetch_ready(fetch_ready),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_is_c  (inst_is_c)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rn, input logic fv, input logic [31:0] fd,
                                 input logic fl, input logic [31:0] fpc, input logic ir);
        reset_n     = rn;
        fetch_valid = fv;
        fetch_data  = fd;
        flush       = fl;
        flush_pc    = fpc;
        inst_ready  = ir;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkInst(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                             input logic is_c);
        checkOutput({tag, "_valid"}, 64'(inst_valid), 64'(1'b1));
        checkOutput({tag, "_inst"}, 64'(inst_out), 64'(inst));
        checkOutput({tag, "_pc"}, 64'(inst_pc), 64'(pc));
        checkOutput({tag, "_is_c"}, 64'(inst_is_c), 64'(is_c));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 64'(inst_valid), 64'(1'b0));
        checkOutput({tag, "_nop"}, 64'(inst_out), 64'(NOP));
        checkOutput({tag, "_is_c"}, 64'(inst_is_c), 64'(1'b0));
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        $display("[TB] start");
        tick();

        // Reset state
        doReset();
        checkIdle("reset");
        checkOutput("reset_fetch_ready", 64'(fetch_ready), 64'(1'b1));
        checkOutput("reset_pc", 64'(inst_pc), 64'h0);

        // Basic: 32-bit then RVC, then the leftover RVC halfword 0x0001
        applyStimulus(1'b1, 1'b1, 32'h00B5_0513, 1'b0, '0, 1'b1);
        checkIdle("basic_empty");
        tick();
        applyStimulus(1'b1, 1'b1, 32'h0001_4501, 1'b0, '0, 1'b1);
        checkInst("basic_i0", 32'h00B5_0513, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        checkInst("basic_i1", 32'h0000_4501, 32'h4, 1'b1);
        tick();
        checkInst("basic_i2", 32'h0000_0001, 32'h6, 1'b1);
        tick();
        checkIdle("basic_drained");
        checkOutput("basic_pc_end", 64'(inst_pc), 64'h8);

        // Straddle across two fetched words
        doReset();
        applyStimulus(1'b1, 1'b1, 32'h0513_4501, 1'b0, '0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        checkInst("strad_rvc", 32'h0000_4501, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h1111_00B5, 1'b0, '0, 1'b1);
        checkIdle("strad_split");
        tick();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        checkInst("strad_32", 32'h00B5_0513, 32'h2, 1'b0);
        tick();
        checkInst("strad_tail", 32'h0000_1111, 32'h6, 1'b1);
        tick();
        checkIdle("strad_drained");

        // Backpressure: buffer holds two 32-bit words, third is refused until space frees
        doReset();
        applyStimulus(1'b1, 1'b1, W0, 1'b0, '0, 1'b0);
        checkOutput("bp_ready0", 64'(fetch_ready), 64'(1'b1));
        tick();
        applyStimulus(1'b1, 1'b1, W1, 1'b0, '0, 1'b0);
        checkOutput("bp_ready1", 64'(fetch_ready), 64'(1'b1));
        tick();
        applyStimulus(1'b1, 1'b1, W2, 1'b0, '0, 1'b0);
        checkOutput("bp_full", 64'(fetch_ready), 64'(1'b0));
        checkInst("bp_hold", W0, 32'h0, 1'b0);
        tick();
        checkOutput("bp_still_full", 64'(fetch_ready), 64'(1'b0));
        applyStimulus(1'b1, 1'b1, W2, 1'b0, '0, 1'b1);
        checkOutput("bp_release_ready", 64'(fetch_ready), 64'(1'b0));
        checkInst("bp_o0", W0, 32'h0, 1'b0);
        tick();
        checkOutput("bp_ready2", 64'(fetch_ready), 64'(1'b1));
        checkInst("bp_o1", W1, 32'h4, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, W3, 1'b0, '0, 1'b1);
        checkInst("bp_o2", W2, 32'h8, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        checkInst("bp_o3", W3, 32'hC, 1'b0);
        tick();
        checkIdle("bp_drained");

        // Flush to an odd halfword: same-cycle fetch dropped, next word's lower half skipped
        doReset();
        applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b1, 32'h0000_0102, 1'b1);
        checkOutput("fl_ready_blocked", 64'(fetch_ready), 64'(1'b0));
        checkIdle("fl_cycle");
        tick();
        applyStimulus(1'b1, 1'b1, 32'hAAAA_BBBB, 1'b0, '0, 1'b1);
        checkOutput("fl_skip_ready", 64'(fetch_ready), 64'(1'b1));
        checkIdle("fl_empty");
        checkOutput("fl_pc", 64'(inst_pc), 64'h102);
        tick();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        checkInst("fl_out", 32'h0000_AAAA, 32'h102, 1'b1);
        tick();
        checkIdle("fl_drained");
        checkOutput("fl_pc_end", 64'(inst_pc), 64'h104);

        // Flush concurrent with pop and push; bit 0 of the target is cleared
        doReset();
        applyStimulus(1'b1, 1'b1, W0, 1'b0, '0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, W1, 1'b1, 32'h0000_0041, 1'b1);
        checkIdle("flc_cycle");
        checkOutput("flc_ready", 64'(fetch_ready), 64'(1'b0));
        tick();
        applyStimulus(1'b1, 1'b1, W2, 1'b0, '0, 1'b1);
        checkIdle("flc_after");
        checkOutput("flc_pc", 64'(inst_pc), 64'h40);
        tick();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        checkInst("flc_out", W2, 32'h40, 1'b0);
        tick();

        // Reset mid-straddle clears the buffer and the PC
        doReset();
        applyStimulus(1'b1, 1'b1, 32'h0513_4501, 1'b0, '0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        checkIdle("rst_mid_split");
        checkOutput("rst_mid_pc_before", 64'(inst_pc), 64'h2);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        checkIdle("rst_mid");
        checkOutput("rst_mid_pc", 64'(inst_pc), 64'h0);
        applyStimulus(1'b1, 1'b1, 32'h0002_0001, 1'b0, '0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
        checkInst("rst_mid_next", 32'h0000_0001, 32'h0, 1'b1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
